// File: rtl/regfile_synth_init.sv
// regfile_synth_init: multi-port register file with registered read data and a
// post-reset clear sequencer that zeroes every entry before the ports go live.
// Optional same-cycle write-to-read forwarding is compiled in with the macro
// REGFILE_SYNTH_INIT_FWD_EN (default build: read-before-write, no forwarding).
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_CLEAR | sequencer writes 0 to entry[cnt_q] each cycle; ports are ignored
// ST_READY | clear done, ready_o = 1, reads/writes live; terminal until reset
module regfile_synth_init #(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int num_rd_p          = 1,
    parameter int num_rs_p          = 2,
    parameter bit x0_tied_to_zero_p = 1'b1,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    output logic                                     ready_o,
    input  logic [num_rd_p-1:0]                      w_v_i,
    input  logic [num_rd_p-1:0][addr_width_lp-1:0]   w_addr_i,
    input  logic [num_rd_p-1:0][width_p-1:0]         w_data_i,
    input  logic [num_rs_p-1:0]                      r_v_i,
    input  logic [num_rs_p-1:0][addr_width_lp-1:0]   r_addr_i,
    output logic [num_rs_p-1:0][width_p-1:0]         r_data_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Entry 0 never needs clearing when it is hardwired to read as zero.
    localparam logic [addr_width_lp-1:0] cnt_start_lp =
        addr_width_lp'(x0_tied_to_zero_p ? 1 : 0);
    localparam logic [addr_width_lp-1:0] cnt_last_lp = addr_width_lp'(els_p - 1);

    state_e                                  state_q, state_d;
    logic [addr_width_lp-1:0]                cnt_q, cnt_d;
    logic [width_p-1:0]                      mem_q [els_p];
    logic [num_rs_p-1:0][width_p-1:0]        r_data_q, r_data_d;
    logic [num_rd_p-1:0]                     w_ok;

    function automatic logic addr_legal(input logic [addr_width_lp-1:0] a);
        addr_legal = ({1'b0, a} < (addr_width_lp + 1)'(els_p)) &&
                     !(x0_tied_to_zero_p && (a == '0));
    endfunction

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == cnt_last_lp) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and clear-counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= cnt_start_lp;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o = (state_q == ST_READY);

    // Per-port write acceptance: only live in READY and only to legal entries.
    always_comb begin
        w_ok = '0;
        for (int i = 0; i < num_rd_p; i++) begin
            w_ok[i] = w_v_i[i] && addr_legal(w_addr_i[i]) && (state_q == ST_READY);
        end
    end

    // Storage: clear sequencer in CLEAR, user writes in READY (higher port wins).
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                for (int i = 0; i < num_rd_p; i++) begin
                    if (w_ok[i]) begin
                        mem_q[w_addr_i[i]] <= w_data_i[i];
                    end
                end
            end
        end
    end

    // Read lane next values: hold when idle, zero in CLEAR or for illegal addresses.
    always_comb begin
        r_data_d = r_data_q;
        for (int j = 0; j < num_rs_p; j++) begin
            if (r_v_i[j]) begin
                if ((state_q == ST_READY) && addr_legal(r_addr_i[j])) begin
                    r_data_d[j] = mem_q[r_addr_i[j]];
`ifdef REGFILE_SYNTH_INIT_FWD_EN
                    for (int i = 0; i < num_rd_p; i++) begin
                        if (w_ok[i] && (w_addr_i[i] == r_addr_i[j])) begin
                            r_data_d[j] = w_data_i[i];
                        end
                    end
`endif
                end else begin
                    r_data_d[j] = '0;
                end
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= r_data_d;
        end
    end

    assign r_data_o = r_data_q;

endmodule

// File: tb/tb_regfile_synth_init.sv
// Testbench for regfile_synth_init: two instances (A: 32 entries, x0 tied,
// 2 write / 2 read ports; B: 20 entries, x0 not tied, 1 write / 1 read port).
module tb_regfile_synth_init;

`ifdef REGFILE_SYNTH_INIT_FWD_EN
    localparam bit fwd_c = 1'b1;
`else
    localparam bit fwd_c = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic                 a_reset;
    logic                 a_ready;
    logic [1:0]           a_w_v;
    logic [1:0][4:0]      a_w_addr;
    logic [1:0][31:0]     a_w_data;
    logic [1:0]           a_r_v;
    logic [1:0][4:0]      a_r_addr;
    logic [1:0][31:0]     a_r_data;

    // Instance B
    logic                 b_reset;
    logic                 b_ready;
    logic [0:0]           b_w_v;
    logic [0:0][4:0]      b_w_addr;
    logic [0:0][31:0]     b_w_data;
    logic [0:0]           b_r_v;
    logic [0:0][4:0]      b_r_addr;
    logic [0:0][31:0]     b_r_data;

    regfile_synth_init #(
        .width_p(32), .els_p(32), .num_rd_p(2), .num_rs_p(2), .x0_tied_to_zero_p(1'b1)
    ) dut_a (
        .clk_i(clk), .reset_i(a_reset), .ready_o(a_ready),
        .w_v_i(a_w_v), .w_addr_i(a_w_addr), .w_data_i(a_w_data),
        .r_v_i(a_r_v), .r_addr_i(a_r_addr), .r_data_o(a_r_data)
    );

    regfile_synth_init #(
        .width_p(32), .els_p(20), .num_rd_p(1), .num_rs_p(1), .x0_tied_to_zero_p(1'b0)
    ) dut_b (
        .clk_i(clk), .reset_i(b_reset), .ready_o(b_ready),
        .w_v_i(b_w_v), .w_addr_i(b_w_addr), .w_data_i(b_w_data),
        .r_v_i(b_r_v), .r_addr_i(b_r_addr), .r_data_o(b_r_data)
    );

    typedef struct {
        logic [1:0]  wv;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  rv;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [1:0] wv, input logic [4:0] wa0,
                                input logic [31:0] wd0, input logic [4:0] wa1,
                                input logic [31:0] wd1, input logic [1:0] rv,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.wv = wv; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.rv = rv; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic a_idle();
        a_w_v = '0; a_w_addr = '0; a_w_data = '0;
        a_r_v = '0; a_r_addr = '0;
    endtask

    task automatic a_step();
        @(posedge clk);
        #1;
    endtask

    // Reset A for 'hold' cycles, then count clear cycles while hammering writes
    // into entries 1..10 and reading entry 5 on lane 0.
    task automatic a_reset_and_clear(input int hold, input string tag);
        int cycles;
        int bad;
        a_reset = 1'b1;
        a_r_v = 2'b01; a_r_addr[0] = 5'd5;
        a_w_v = 2'b11;
        a_w_addr[0] = 5'd3; a_w_data[0] = 32'hFFFF_0001;
        a_w_addr[1] = 5'd4; a_w_data[1] = 32'hFFFF_0002;
        repeat (hold) a_step();
        chk({tag, "_rst_ready"}, {31'd0, a_ready}, 32'd0);
        chk({tag, "_rst_lane0"}, a_r_data[0], 32'd0);
        chk({tag, "_rst_lane1"}, a_r_data[1], 32'd0);
        a_reset = 1'b0;
        cycles = 0;
        bad = 0;
        while (!a_ready && cycles < 100) begin
            a_w_addr[0] = 5'($urandom_range(1, 10));
            a_w_addr[1] = 5'($urandom_range(1, 10));
            a_w_data[0] = $urandom | 32'h1;
            a_w_data[1] = $urandom | 32'h1;
            a_step();
            cycles++;
            if (a_r_data[0] !== 32'd0) bad++;
        end
        a_idle();
        chk({tag, "_clear_len"}, cycles, 32'd31);
        chk({tag, "_clear_rd"}, bad, 32'd0);
    endtask

    task automatic a_read_1_to_10_zero(input string tag);
        for (int k = 1; k <= 10; k++) begin
            a_r_v = 2'b01; a_r_addr[0] = 5'(k);
            a_step();
            chk($sformatf("%s_e%0d", tag, k), a_r_data[0], 32'd0);
        end
        a_idle();
    endtask

    logic [31:0] m_mem  [32];
    logic [31:0] m_lane [2];

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_idle();
        b_w_v = '0; b_w_addr = '0; b_w_data = '0; b_r_v = '0; b_r_addr = '0;

        // ---- A: reset/clear timing, writes during CLEAR ignored ----
        a_reset_and_clear(3, "a0");
        a_read_1_to_10_zero("a0_after_clear");

        // ---- A: table-driven vectors (contents all zero, lanes 0) ----
        vecs[0]  = mk(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0, 32'd0, 32'd0);
        vecs[1]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'd7, 5'd0, 32'hDEADBEEF, 32'd0);
        vecs[2]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0);
        vecs[3]  = mk(2'b01, 5'd9, 32'h11, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0);
        vecs[4]  = mk(2'b01, 5'd9, 32'h22, 5'd0, 32'd0, 2'b11, 5'd9, 5'd7,
                      fwd_c ? 32'h22 : 32'h11, 32'hDEADBEEF);
        vecs[5]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd9, 5'd0, 32'h22, 32'hDEADBEEF);
        vecs[6]  = mk(2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 2'b11, 5'd3, 5'd3,
                      fwd_c ? 32'hB : 32'h0, fwd_c ? 32'hB : 32'h0);
        vecs[7]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd3, 5'd0,
                      32'hB, fwd_c ? 32'hB : 32'h0);
        vecs[8]  = mk(2'b11, 5'd0, 32'h55, 5'd3, 32'hC, 2'b11, 5'd0, 5'd3,
                      32'h0, fwd_c ? 32'hC : 32'hB);
        vecs[9]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd3, 32'h0, 32'hC);
        vecs[10] = mk(2'b11, 5'd12, 32'h77, 5'd12, 32'h88, 2'b10, 5'd0, 5'd12,
                      32'h0, fwd_c ? 32'h88 : 32'h0);
        vecs[11] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b10, 5'd0, 5'd12, 32'h0, 32'h88);

        for (int k = 0; k < 12; k++) begin
            a_w_v = vecs[k].wv;
            a_w_addr[0] = vecs[k].wa0; a_w_data[0] = vecs[k].wd0;
            a_w_addr[1] = vecs[k].wa1; a_w_data[1] = vecs[k].wd1;
            a_r_v = vecs[k].rv;
            a_r_addr[0] = vecs[k].ra0; a_r_addr[1] = vecs[k].ra1;
            a_step();
            chk($sformatf("vec%0d_l0", k), a_r_data[0], vecs[k].e0);
            chk($sformatf("vec%0d_l1", k), a_r_data[1], vecs[k].e1);
        end
        a_idle();

        // ---- A: mid-operation reset ----
        for (int k = 1; k <= 10; k++) begin
            a_w_v = 2'b10; a_w_addr[1] = 5'(k); a_w_data[1] = 32'h1111 * k + 32'h1;
            a_step();
        end
        a_idle();
        a_r_v = 2'b10; a_r_addr[1] = 5'd10;
        a_step();
        chk("mid_fill_e10", a_r_data[1], 32'h1111 * 10 + 32'h1);
        a_idle();
        a_reset_and_clear(1, "mid");
        a_read_1_to_10_zero("mid_after_clear");

        // ---- A: randomized traffic against a reference model ----
        for (int e = 0; e < 32; e++) m_mem[e] = 32'd0;
        m_lane[0] = 32'd0;
        m_lane[1] = a_r_data[1] === 32'd0 ? 32'd0 : 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  wv, rv;
            logic [4:0]  wa [2];
            logic [4:0]  ra [2];
            logic [31:0] wd [2];
            wv = 2'($urandom);
            rv = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                wa[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                ra[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                wd[i] = $urandom;
            end
            // Expected lanes: old contents, optionally overridden by the last
            // same-cycle writer to that address; entry 0 always reads zero.
            for (int j = 0; j < 2; j++) begin
                if (rv[j]) begin
                    if (ra[j] == 5'd0) begin
                        m_lane[j] = 32'd0;
                    end else begin
                        m_lane[j] = m_mem[ra[j]];
                        if (fwd_c) begin
                            for (int i = 0; i < 2; i++)
                                if (wv[i] && wa[i] == ra[j]) m_lane[j] = wd[i];
                        end
                    end
                end
            end
            for (int i = 0; i < 2; i++)
                if (wv[i] && wa[i] != 5'd0) m_mem[wa[i]] = wd[i];

            a_w_v = wv; a_r_v = rv;
            for (int i = 0; i < 2; i++) begin
                a_w_addr[i] = wa[i]; a_w_data[i] = wd[i]; a_r_addr[i] = ra[i];
            end
            a_step();
            chk($sformatf("rand%0d_l0", n), a_r_data[0], m_lane[0]);
            chk($sformatf("rand%0d_l1", n), a_r_data[1], m_lane[1]);
        end
        a_idle();
        a_reset = 1'b1;

        // ---- B: clear timing with x0 not tied, out-of-range writes ----
        begin
            int cycles;
            int bad;
            b_r_v = 1'b1; b_r_addr[0] = 5'd5;
            a_step();
            chk("b_rst_ready", {31'd0, b_ready}, 32'd0);
            chk("b_rst_lane", b_r_data[0], 32'd0);
            b_reset = 1'b0;
            cycles = 0;
            bad = 0;
            while (!b_ready && cycles < 100) begin
                b_w_v = 1'b1; b_w_addr[0] = 5'($urandom_range(0, 19)); b_w_data[0] = $urandom | 32'h1;
                a_step();
                cycles++;
                if (b_r_data[0] !== 32'd0) bad++;
            end
            b_w_v = '0; b_r_v = '0;
            chk("b_clear_len", cycles, 32'd20);
            chk("b_clear_rd", bad, 32'd0);
        end
        b_w_v = 1'b1; b_w_addr[0] = 5'd25; b_w_data[0] = 32'h55;
        a_step();
        b_w_v = 1'b1; b_w_addr[0] = 5'd0; b_w_data[0] = 32'h5A;
        a_step();
        b_w_v = '0;
        for (int k = 0; k < 20; k++) begin
            b_r_v = 1'b1; b_r_addr[0] = 5'(k);
            a_step();
            chk($sformatf("b_e%0d", k), b_r_data[0], (k == 0) ? 32'h5A : 32'd0);
        end
        b_r_v = 1'b1; b_r_addr[0] = 5'd25;
        a_step();
        chk("b_oob_read", b_r_data[0], 32'd0);
        b_r_v = '0;
        b_w_v = 1'b1; b_w_addr[0] = 5'd19; b_w_data[0] = 32'h66;
        a_step();
        b_w_v = '0; b_r_v = 1'b1; b_r_addr[0] = 5'd19;
        a_step();
        chk("b_last_entry", b_r_data[0], 32'h66);
        b_r_v = '0;
        a_step();
        chk("b_hold", b_r_data[0], 32'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
